// File: rtl/nav_pkg.sv
// Shared types and constants for the camera navigation sequencer.
package nav_pkg;

  typedef enum logic [1:0] {
    COLOR_RED   = 2'b00,
    COLOR_GREEN = 2'b01,
    COLOR_BLUE  = 2'b10,
    COLOR_WHITE = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    DET_NONE   = 3'b000,
    DET_RIGHT  = 3'b001,
    DET_MIDDLE = 3'b010,
    DET_LEFT   = 3'b100
  } det_t;

  typedef enum logic [1:0] {
    MOTOR_STOP  = 2'b00,
    MOTOR_FWD   = 2'b01,
    MOTOR_ROT_L = 2'b10,
    MOTOR_ROT_R = 2'b11
  } motor_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_DWELL   = 3'd4
  } nav_state_t;

  typedef enum logic {
    LEG_TABLE   = 1'b0,
    LEG_KITCHEN = 1'b1
  } leg_t;

  localparam color_t COLOR_RESET = COLOR_WHITE;
  localparam motor_t MOTOR_RESET = MOTOR_STOP;

  // Any pattern other than a single known bit is no colour.
  function automatic det_t decode_det(input logic [2:0] raw);
    case (raw)
      3'b100:  return DET_LEFT;
      3'b010:  return DET_MIDDLE;
      3'b001:  return DET_RIGHT;
      default: return DET_NONE;
    endcase
  endfunction

  function automatic motor_t rot_for(input det_t dir);
    return (dir == DET_LEFT) ? MOTOR_ROT_L : MOTOR_ROT_R;
  endfunction

endpackage

// File: rtl/nav_frame_counter.sv
// Saturating frame counter; hit_c flags that the next increment reaches LIMIT.
module nav_frame_counter #(
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit_c
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  assign hit_c = (count >= W'(LIMIT - 1));

endmodule

// File: rtl/cam_nav_sequencer.sv
// Mission controller: scan/confirm/drive to a table, dwell, return to kitchen.
// Optional scan timeout abort enabled by defining NAV_TIMEOUT_EN.
module cam_nav_sequencer
  import nav_pkg::*;
#(
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned LOST_FRAMES    = 4,
  parameter int unsigned DWELL_FRAMES   = 30,
  parameter int unsigned TIMEOUT_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       order_valid,
  input  logic [1:0] order_color,
  output logic       order_ready,
  input  logic       frame_done,
  input  logic [2:0] det_mode,
  input  logic       obstacle_near,
  output logic [1:0] color_mode,
  output logic [1:0] motor_cmd,
  output logic       busy,
  output logic       leg_done,
  output logic       abort
);

  nav_state_t state_q, state_d;
  leg_t       leg_q, leg_d;
  color_t     color_q, color_d;
  motor_t     motor_q, motor_d;
  det_t       last_dir_q, last_dir_d;
  logic       leg_done_q, leg_done_d;
  logic       abort_q, abort_d;
  logic       busy_q, order_ready_q;

  det_t det;
  det_t turn_dir;
  logic confirm_inc, confirm_clr, confirm_hit_c;
  logic lost_inc, lost_clr, lost_hit_c;
  logic dwell_inc, dwell_clr, dwell_hit_c;

  assign det      = decode_det(det_mode);
  // Direction to rotate after this verdict: a side verdict, else the last known side.
  assign turn_dir = (det == DET_LEFT || det == DET_RIGHT) ? det : last_dir_q;

  nav_frame_counter #(.LIMIT(CONFIRM_FRAMES)) u_confirm (
    .clk(clk), .reset(reset), .clr(confirm_clr), .inc(confirm_inc), .hit_c(confirm_hit_c)
  );
  nav_frame_counter #(.LIMIT(LOST_FRAMES)) u_lost (
    .clk(clk), .reset(reset), .clr(lost_clr), .inc(lost_inc), .hit_c(lost_hit_c)
  );
  nav_frame_counter #(.LIMIT(DWELL_FRAMES)) u_dwell (
    .clk(clk), .reset(reset), .clr(dwell_clr), .inc(dwell_inc), .hit_c(dwell_hit_c)
  );

`ifdef NAV_TIMEOUT_EN
  logic scan_inc, scan_clr, scan_hit_c;

  nav_frame_counter #(.LIMIT(TIMEOUT_FRAMES)) u_timeout (
    .clk(clk), .reset(reset), .clr(scan_clr), .inc(scan_inc), .hit_c(scan_hit_c)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      leg_q         <= LEG_TABLE;
      color_q       <= COLOR_RESET;
      motor_q       <= MOTOR_RESET;
      last_dir_q    <= DET_RIGHT;
      leg_done_q    <= 1'b0;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
      order_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      leg_q         <= leg_d;
      color_q       <= color_d;
      motor_q       <= motor_d;
      last_dir_q    <= last_dir_d;
      leg_done_q    <= leg_done_d;
      abort_q       <= abort_d;
      busy_q        <= (state_d != ST_IDLE);
      order_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Counters clear outside their own state unless the state below says otherwise.
  always_comb begin
    state_d     = state_q;
    leg_d       = leg_q;
    color_d     = color_q;
    motor_d     = motor_q;
    last_dir_d  = last_dir_q;
    leg_done_d  = 1'b0;
    abort_d     = 1'b0;
    confirm_inc = 1'b0;
    confirm_clr = 1'b1;
    lost_inc    = 1'b0;
    lost_clr    = 1'b1;
    dwell_inc   = 1'b0;
    dwell_clr   = 1'b1;
`ifdef NAV_TIMEOUT_EN
    scan_inc    = 1'b0;
    scan_clr    = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (order_valid && order_ready_q && (order_color != 2'(COLOR_WHITE))) begin
          state_d = ST_SCAN;
          leg_d   = LEG_TABLE;
          color_d = color_t'(order_color);
          motor_d = rot_for(last_dir_q);
        end
      end
      ST_SCAN: begin
        confirm_clr = 1'b0;
`ifdef NAV_TIMEOUT_EN
        scan_clr = 1'b0;
        scan_inc = frame_done;
`endif
        if (frame_done) begin
          if (det == DET_MIDDLE) begin
            state_d     = ST_CONFIRM;
            motor_d     = MOTOR_STOP;
            confirm_inc = 1'b1;
          end else begin
            last_dir_d = turn_dir;
            motor_d    = rot_for(turn_dir);
`ifdef NAV_TIMEOUT_EN
            if (scan_hit_c) begin
              state_d = ST_IDLE;
              motor_d = MOTOR_STOP;
              color_d = COLOR_WHITE;
              abort_d = 1'b1;
            end
`endif
          end
        end
      end
      ST_CONFIRM: begin
        confirm_clr = 1'b0;
        if (frame_done) begin
          if (det == DET_MIDDLE) begin
            confirm_inc = 1'b1;
            if (confirm_hit_c) begin
              state_d     = ST_DRIVE;
              motor_d     = MOTOR_FWD;
              confirm_clr = 1'b1;
            end
          end else begin
            confirm_clr = 1'b1;
            state_d     = ST_SCAN;
            last_dir_d  = turn_dir;
            motor_d     = rot_for(turn_dir);
          end
        end
      end
      ST_DRIVE: begin
        lost_clr = 1'b0;
        // Arrival takes priority over any frame verdict in the same cycle.
        if (obstacle_near) begin
          motor_d    = MOTOR_STOP;
          leg_done_d = 1'b1;
          state_d    = (leg_q == LEG_TABLE) ? ST_DWELL : ST_IDLE;
        end else if (frame_done) begin
          if (det == DET_MIDDLE) begin
            lost_clr = 1'b1;
          end else begin
            lost_inc   = 1'b1;
            last_dir_d = turn_dir;
            if (lost_hit_c) begin
              state_d = ST_SCAN;
              motor_d = rot_for(turn_dir);
            end
          end
        end
      end
      ST_DWELL: begin
        dwell_clr = 1'b0;
        if (frame_done) begin
          dwell_inc = 1'b1;
          if (dwell_hit_c) begin
            state_d    = ST_SCAN;
            leg_d      = LEG_KITCHEN;
            color_d    = COLOR_WHITE;
            last_dir_d = DET_RIGHT;
            motor_d    = MOTOR_ROT_R;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        motor_d = MOTOR_STOP;
      end
    endcase
  end

  assign order_ready = order_ready_q;
  assign color_mode  = color_q;
  assign motor_cmd   = motor_q;
  assign busy        = busy_q;
  assign leg_done    = leg_done_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_cam_nav_sequencer.sv
// Directed bench for cam_nav_sequencer with a phase-level reference model.
// Honours NAV_TIMEOUT_EN the same way as the design.
module tb_cam_nav_sequencer;

  localparam int CONFIRM_N = 3;
  localparam int LOST_N    = 4;
  localparam int DWELL_N   = 30;
  localparam int TIMEOUT_N = 120;

  localparam int P_IDLE    = 0;
  localparam int P_SCAN    = 1;
  localparam int P_CONFIRM = 2;
  localparam int P_DRIVE   = 3;
  localparam int P_DWELL   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       order_valid = 1'b0;
  logic [1:0] order_color = 2'b00;
  logic       order_ready;
  logic       frame_done = 1'b0;
  logic [2:0] det_mode = 3'b000;
  logic       obstacle_near = 1'b0;
  logic [1:0] color_mode;
  logic [1:0] motor_cmd;
  logic       busy;
  logic       leg_done;
  logic       abort;

  int total = 0;
  int bad   = 0;

  cam_nav_sequencer dut (
    .clk(clk), .reset(reset), .order_valid(order_valid), .order_color(order_color),
    .order_ready(order_ready), .frame_done(frame_done), .det_mode(det_mode),
    .obstacle_near(obstacle_near), .color_mode(color_mode), .motor_cmd(motor_cmd),
    .busy(busy), .leg_done(leg_done), .abort(abort)
  );

  always #5 clk = ~clk;

  // Reference model: mission phase plus plain integer frame tallies.
  int         m_phase = P_IDLE;
  bit         m_kitchen = 1'b0;
  bit         m_left = 1'b0;
  logic [1:0] m_color = 2'b11;
  int         m_hits = 0, m_lost = 0, m_dwell = 0, m_scan = 0;
  bit         m_leg_done = 1'b0, m_abort = 1'b0;
  bit         m_init = 1'b0;

  always @(posedge clk) begin : model
    int d;
    m_leg_done = 1'b0;
    m_abort    = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; m_kitchen = 1'b0; m_left = 1'b0; m_color = 2'b11;
      m_hits = 0; m_lost = 0; m_dwell = 0; m_scan = 0; m_init = 1'b1;
    end else begin
      d = (det_mode == 3'b100) ? 1 : (det_mode == 3'b010) ? 2 : (det_mode == 3'b001) ? 3 : 0;
      case (m_phase)
        P_IDLE: if (order_valid && order_color != 2'b11) begin
          m_phase = P_SCAN; m_kitchen = 1'b0; m_color = order_color;
        end
        P_SCAN: if (frame_done) begin
          if (d == 2) begin
            m_phase = P_CONFIRM; m_hits = 1;
          end else begin
            if (d == 1) m_left = 1'b1;
            if (d == 3) m_left = 1'b0;
`ifdef NAV_TIMEOUT_EN
            m_scan++;
            if (m_scan == TIMEOUT_N) begin
              m_phase = P_IDLE; m_color = 2'b11; m_abort = 1'b1;
            end
`endif
          end
        end
        P_CONFIRM: if (frame_done) begin
          if (d == 2) begin
            m_hits++;
            if (m_hits == CONFIRM_N) begin m_phase = P_DRIVE; m_lost = 0; end
          end else begin
            if (d == 1) m_left = 1'b1;
            if (d == 3) m_left = 1'b0;
            m_phase = P_SCAN;
          end
        end
        P_DRIVE: begin
          if (obstacle_near) begin
            m_leg_done = 1'b1; m_dwell = 0;
            m_phase = m_kitchen ? P_IDLE : P_DWELL;
          end else if (frame_done) begin
            if (d == 2) m_lost = 0;
            else begin
              if (d == 1) m_left = 1'b1;
              if (d == 3) m_left = 1'b0;
              m_lost++;
              if (m_lost == LOST_N) m_phase = P_SCAN;
            end
          end
        end
        P_DWELL: if (frame_done) begin
          m_dwell++;
          if (m_dwell == DWELL_N) begin
            m_kitchen = 1'b1; m_color = 2'b11; m_left = 1'b0; m_phase = P_SCAN;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (m_phase != P_SCAN) m_scan = 0;
    end
  end

  function automatic logic [1:0] motor_for(input int phase, input bit left);
    case (phase)
      P_SCAN:  return left ? 2'b10 : 2'b11;
      P_DRIVE: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Per-cycle comparison of every output against the model, on the falling edge.
  always @(negedge clk) begin
    logic [7:0] act, exp;
    if (m_init) begin
      act = {order_ready, color_mode, motor_cmd, busy, leg_done, abort};
      exp = {m_phase == P_IDLE, m_color, motor_for(m_phase, m_left),
             m_phase != P_IDLE, m_leg_done, m_abort};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model_cycle t=%0t: got rdy/col/mot/busy/done/abrt=%b expected %b",
                 $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [2:0] d);
    frame_done = 1'b1;
    det_mode   = d;
    tick();
    frame_done = 1'b0;
    det_mode   = 3'b000;
    tick();
  endtask

  // Like frame() but leaves the bench just after the deciding edge.
  task automatic frame_now(input logic [2:0] d);
    frame_done = 1'b1;
    det_mode   = d;
    tick();
    frame_done = 1'b0;
    det_mode   = 3'b000;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    check("rst_color", 4'(color_mode), 4'h3);
    check("rst_motor", 4'(motor_cmd), 4'h0);
    check("rst_flags", {busy, order_ready, leg_done, abort}, 4'b0100);

    // Blue order, three MIDDLE frames into DRIVE.
    order_valid = 1'b1; order_color = 2'b10;
    tick();
    order_valid = 1'b0;
    check("t1_color", 4'(color_mode), 4'h2);
    check("t1_rot_r", 4'(motor_cmd), 4'h3);
    check("t1_busy", {busy, order_ready}, 4'b0010);
    frame_now(3'b010);
    check("t1_stop", 4'(motor_cmd), 4'h0);
    tick(3);
    check("t1_hold", 4'(motor_cmd), 4'h0);
    frame(3'b010);
    frame_now(3'b010);
    check("t1_fwd", 4'(motor_cmd), 4'h1);
    tick();

    // Arrival together with a NO_COLOR frame, then dwell.
    obstacle_near = 1'b1;
    frame_now(3'b000);
    obstacle_near = 1'b0;
    check("t2_arrive", {motor_cmd, leg_done, busy}, 4'b0011);
    tick();
    check("t2_pulse", 4'(leg_done), 4'h0);
    for (int i = 0; i < DWELL_N - 1; i++) frame(3'b000);
    check("t2_dwell_col", 4'(color_mode), 4'h2);
    frame_now(3'b001);
    check("t2_white", {color_mode, motor_cmd}, 4'b1111);
    tick();

    // Scan LEFT, MIDDLE, RIGHT.
    frame_now(3'b100);
    check("t3_rot_l", 4'(motor_cmd), 4'h2);
    tick();
    frame_now(3'b010);
    check("t3_confirm", 4'(motor_cmd), 4'h0);
    tick();
    frame_now(3'b001);
    check("t3_rescan", 4'(motor_cmd), 4'h3);
    tick();

    // Lost-target handling in DRIVE; 110 counts as no colour.
    for (int i = 0; i < CONFIRM_N; i++) frame(3'b010);
    check("t4_fwd", 4'(motor_cmd), 4'h1);
    frame(3'b000); frame(3'b000); frame(3'b110); frame(3'b010);
    check("t4_stay", 4'(motor_cmd), 4'h1);
    frame(3'b000); frame(3'b110); frame(3'b000);
    check("t4_stay3", 4'(motor_cmd), 4'h1);
    frame_now(3'b000);
    check("t4_lost", {motor_cmd, busy, order_ready}, 4'b1110);
    tick();

    // Kitchen leg with an order held while busy.
    order_valid = 1'b1; order_color = 2'b00;
    for (int i = 0; i < CONFIRM_N; i++) frame(3'b010);
    check("t5_busy_rdy", {busy, order_ready, motor_cmd}, 4'b1001);
    obstacle_near = 1'b1;
    tick();
    obstacle_near = 1'b0;
    order_valid   = 1'b0;
    check("t5_arrive", {busy, order_ready, leg_done, motor_cmd == 2'b00}, 4'b0111);
    check("t5_color", 4'(color_mode), 4'h3);
    tick();
    check("t5_idle", {busy, order_ready, leg_done, abort}, 4'b0100);
    order_valid = 1'b1; order_color = 2'b11;
    tick();
    order_valid = 1'b0;
    check("t5_illegal", {busy, order_ready, color_mode}, 4'b0111);

    // Unbounded scan or timeout abort.
    order_valid = 1'b1; order_color = 2'b00;
    tick();
    order_valid = 1'b0;
    check("t6_red", {color_mode, motor_cmd}, 4'b0011);
`ifdef NAV_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_N - 1; i++) frame(3'b000);
    check("t6_pre", {busy, abort}, 4'b0010);
    frame_now(3'b000);
    check("t6_abort", {busy, abort, motor_cmd}, 4'b0100);
    check("t6_white", 4'(color_mode), 4'h3);
    tick();
    check("t6_pulse", 4'(abort), 4'h0);
`else
    for (int i = 0; i < 500; i++) frame(3'b000);
    check("t6_scan", {busy, abort, motor_cmd}, 4'b1011);
`endif

    // Reset in the middle of DRIVE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    order_valid = 1'b1; order_color = 2'b01;
    tick();
    order_valid = 1'b0;
    for (int i = 0; i < CONFIRM_N; i++) frame(3'b010);
    check("t7_fwd", {color_mode, motor_cmd}, 4'b0101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_reset", {color_mode, motor_cmd}, 4'b1100);
    check("t7_flags", {busy, order_ready, leg_done, abort}, 4'b0100);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
